ahb_apb_bridge: RTL and testbench



---
 rtl/ahb_apb_bridge.sv | 171 +++++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-Lite slave to APB4 master bridge; optional PSLVERR->ERROR mapping via AHB_APB_BRIDGE_ERRRESP_EN
module ahb_apb_bridge #(
  parameter int ADDRWIDTH      = 12,
  parameter bit REGISTER_RDATA = 1'b1,
  parameter bit REGISTER_WDATA = 1'b0
) (
  input  logic                 hclk_i,
  input  logic                 hreset_i,
  input  logic                 pclken_i,
  input  logic                 hsel_i,
  input  logic [ADDRWIDTH-1:0] haddr_i,
  input  logic [1:0]           htrans_i,
  input  logic [2:0]           hsize_i,
  input  logic [3:0]           hprot_i,
  input  logic                 hwrite_i,
  input  logic                 hready_i,
  input  logic [31:0]          hwdata_i,
  output logic                 hreadyout_o,
  output logic [31:0]          hrdata_o,
  output logic                 hresp_o,
  output logic [ADDRWIDTH-1:0] paddr_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [3:0]           pstrb_o,
  output logic [2:0]           pprot_o,
  output logic [31:0]          pwdata_o,
  output logic                 psel_o,
  input  logic [31:0]          prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  output logic                 apbactive_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [3:0]             pstrb_q;
  logic [2:0]             pprot_q;
  logic [3:0]             strb_calc;
  logic                   accept;
  logic                   apb_done;
  logic                   slv_err;
  logic                   unused_inputs;

  // A new transfer may start from IDLE or from DONE (back-to-back); ERR2 never accepts.
  assign accept   = hsel_i & htrans_i[1] & hready_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign apb_done = (state_q == S_ACCESS) & pclken_i & pready_i;

`ifdef AHB_APB_BRIDGE_ERRRESP_EN
  assign slv_err = pslverr_i;
  assign hresp_o = (state_q == S_ERR1) | (state_q == S_ERR2);
  assign unused_inputs = ^{hprot_i[3:2], htrans_i[0]};
`else
  assign slv_err = 1'b0;
  assign hresp_o = 1'b0;
  assign unused_inputs = ^{hprot_i[3:2], htrans_i[0], pslverr_i};
`endif

  assign apbactive_o = (hsel_i & htrans_i[1]) | (state_q != S_IDLE);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;

  // State register; reset abandons any APB transfer in flight.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        hreadyout_o = 1'b0;
        if (pclken_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        hreadyout_o = 1'b0;
        psel_o      = 1'b1;
        if (pclken_i) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        hreadyout_o = 1'b0;
        psel_o      = 1'b1;
        penable_o   = 1'b1;
        if (apb_done) state_d = slv_err ? S_ERR1 : S_DONE;
      end
      S_DONE: begin
        state_d = accept ? S_WAIT : S_IDLE;
      end
      S_ERR1: begin
        hreadyout_o = 1'b0;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte-lane strobes from transfer size and low address bits.
  always_comb begin
    strb_calc = 4'b1111;
    case (hsize_i)
      3'd0:    strb_calc = 4'b0001 << haddr_i[1:0];
      3'd1:    strb_calc = haddr_i[1] ? 4'b1100 : 4'b0011;
      default: strb_calc = 4'b1111;
    endcase
  end

  // Capture the AHB address phase; held stable through SETUP and ACCESS.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= 4'b0000;
      pprot_q  <= 3'b000;
    end else if (accept) begin
      paddr_q  <= {haddr_i[ADDRWIDTH-1:2], 2'b00};
      pwrite_q <= hwrite_i;
      pstrb_q  <= hwrite_i ? strb_calc : 4'b0000;
      pprot_q  <= {~hprot_i[0], 1'b0, hprot_i[1]};
    end
  end

  if (REGISTER_RDATA) begin : g_rdata_reg
    logic [31:0] hrdata_q;
    // Hold the read data returned on the APB completion edge.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
      if (hreset_i)      hrdata_q <= 32'h0;
      else if (apb_done) hrdata_q <= prdata_i;
    end
    assign hrdata_o = hrdata_q;
  end else begin : g_rdata_pass
    assign hrdata_o = (state_q == S_DONE) ? prdata_i : 32'h0;
  end

  if (REGISTER_WDATA) begin : g_wdata_reg
    logic [31:0] pwdata_q;
    // HWDATA is valid in the AHB data phase, which coincides with WAIT.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
      if (hreset_i)                pwdata_q <= 32'h0;
      else if (state_q == S_WAIT)  pwdata_q <= hwdata_i;
    end
    assign pwdata_o = pwdata_q;
  end else begin : g_wdata_pass
    assign pwdata_o = hwdata_i;
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - randomized self-checking bench for ahb_apb_bridge against a transfer-level model
module tb_ahb_apb_bridge;
  localparam int AW = 12;
`ifdef AHB_APB_BRIDGE_ERRRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pclken;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [3:0]    hprot;
  logic          hwrite;
  logic          hready;
  logic [31:0]   hwdata;
  logic          hreadyout;
  logic [31:0]   hrdata;
  logic          hresp;
  logic [AW-1:0] paddr;
  logic          penable;
  logic          pwrite;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [31:0]   pwdata;
  logic          psel;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          apbactive;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          pdiv    = 2;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  // The interconnect feeds the slave's own HREADYOUT back as HREADY.
  assign hready = hreadyout;

  ahb_apb_bridge #(.ADDRWIDTH(AW), .REGISTER_RDATA(1'b1), .REGISTER_WDATA(1'b0)) dut (
    .hclk_i(clk), .hreset_i(rst), .pclken_i(pclken),
    .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans), .hsize_i(hsize), .hprot_i(hprot),
    .hwrite_i(hwrite), .hready_i(hready), .hwdata_i(hwdata),
    .hreadyout_o(hreadyout), .hrdata_o(hrdata), .hresp_o(hresp),
    .paddr_o(paddr), .penable_o(penable), .pwrite_o(pwrite), .pstrb_o(pstrb), .pprot_o(pprot),
    .pwdata_o(pwdata), .psel_o(psel),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr), .apbactive_o(apbactive)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] exp_strb(input logic wr, input logic [2:0] sz, input logic [1:0] a);
    if (!wr) return 4'b0000;
    case (sz)
      3'd0:    return 4'(1 << a);
      3'd1:    return (a >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic exp_err(input logic slverr);
    return slverr & ERR_EN;
  endfunction

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One AHB transfer driven from a negedge where the bridge is ready; returns at the negedge
  // after the response has completed (DONE cycle, or IDLE after an error pair).
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [2:0] sz,
                         input logic [3:0] prot, input logic [31:0] wdata, input int waits,
                         input logic slverr, input logic abort);
    logic [3:0]    es;
    logic [2:0]    ep;
    logic [AW-1:0] ea;
    int            widx, setups, en_access, budget, waits_left;
    logic          stall_ok, attr_ok, completing, done, prev_psel;
    es   = exp_strb(wr, sz, addr[1:0]);
    ep   = {~prot[0], 1'b0, prot[1]};
    ea   = {addr[AW-1:2], 2'b00};
    widx = int'(addr[AW-1:2]);
    chk_eq("ready_before_accept", 32'(hreadyout), 32'd1);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz; hprot = prot;
    pready = 1'b0; pslverr = 1'b0;
    pclken = ((cyc % pdiv) == 0);
    #1;
    chk_eq("apbactive_pending", 32'(apbactive), 32'd1);
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    haddr = AW'($urandom); hwrite = 1'($urandom); hsize = 3'($urandom); hprot = 4'($urandom);
    setups = 0; en_access = 0; budget = 0; waits_left = waits;
    stall_ok = 1'b1; attr_ok = 1'b1; completing = 1'b0; done = 1'b0; prev_psel = 1'b0;
    while (!done && budget < 300) begin
      budget++;
      if (psel && !penable && !prev_psel) begin
        setups++;
        chk_eq("paddr", 32'(paddr), 32'(ea));
        chk_eq("pwrite", 32'(pwrite), 32'(wr));
        chk_eq("pstrb", 32'(pstrb), 32'(es));
        chk_eq("pprot", 32'(pprot), 32'(ep));
        if (wr) chk_eq("pwdata", pwdata, wdata);
      end
      prev_psel = psel;
      if (hreadyout !== 1'b0 || apbactive !== 1'b1 || hresp !== 1'b0) stall_ok = 1'b0;
      if (psel && (paddr !== ea || pwrite !== wr || pstrb !== es || pprot !== ep)) attr_ok = 1'b0;
      if (abort && psel && penable) begin
        rst = 1'b1; pready = 1'b0;
        #1;
        chk_eq("rst_psel", 32'(psel), 32'd0);
        chk_eq("rst_penable", 32'(penable), 32'd0);
        chk_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk_eq("rst_apbactive", 32'(apbactive), 32'd0);
        chk_eq("rst_paddr", 32'(paddr), 32'd0);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        chk_eq("abort_stall", 32'(stall_ok), 32'd1);
        return;
      end
      pclken = ((cyc % pdiv) == 0);
      if (psel && penable && pclken) begin
        en_access++;
        if (waits_left == 0) begin
          pready = 1'b1; pslverr = slverr; completing = 1'b1;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); waits_left--;
        end
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom);
      end
      prdata = mem[widx];
      tick();
      if (completing) done = 1'b1;
    end
    chk_eq("setup_phases", 32'(setups), 32'd1);
    chk_eq("access_edges", 32'(en_access), 32'(waits + 1));
    chk_eq("stall_outputs", 32'(stall_ok), 32'd1);
    chk_eq("attr_stable", 32'(attr_ok), 32'd1);
    if (!done) begin
      chk_eq("timeout", 32'(done), 32'd1);
      return;
    end
    pready = 1'b0; pslverr = 1'b0;
    chk_eq("psel_drop", 32'({psel, penable}), 32'd0);
    if (exp_err(slverr)) begin
      chk_eq("err1_ready", 32'(hreadyout), 32'd0);
      chk_eq("err1_resp", 32'(hresp), 32'd1);
      tick();
      chk_eq("err2_ready", 32'(hreadyout), 32'd1);
      chk_eq("err2_resp", 32'(hresp), 32'd1);
      tick();
      chk_eq("err_idle_resp", 32'(hresp), 32'd0);
    end else begin
      chk_eq("done_ready", 32'(hreadyout), 32'd1);
      chk_eq("done_resp", 32'(hresp), 32'd0);
      if (!wr) chk_eq("hrdata", hrdata, mem[widx]);
    end
    if (wr && !slverr) begin
      for (int b = 0; b < 4; b++)
        if (es[b]) mem[widx][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]    sz;
    logic [AW-1:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst = 1'b1; pclken = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'd0;
    hprot = 4'd0; hwrite = 1'b0; hwdata = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("reset_hreadyout", 32'(hreadyout), 32'd1);
    chk_eq("reset_hresp", 32'(hresp), 32'd0);
    chk_eq("reset_hrdata", hrdata, 32'd0);
    chk_eq("reset_psel_penable", 32'({psel, penable}), 32'd0);
    chk_eq("reset_paddr", 32'(paddr), 32'd0);
    chk_eq("reset_pwrite_pstrb_pprot", 32'({pwrite, pstrb, pprot}), 32'd0);
    chk_eq("reset_apbactive", 32'(apbactive), 32'd0);
    rst = 1'b0;
    tick();

    // BUSY and IDLE transfer types are ignored.
    hsel = 1'b1; htrans = 2'b01;
    tick();
    chk_eq("busy_ignored", 32'({hreadyout, psel, apbactive, hresp}), 32'b1000);
    htrans = 2'b00;
    tick();
    chk_eq("idle_ignored", 32'({hreadyout, psel, apbactive, hresp}), 32'b1000);
    idle(1);

    pdiv = 2;
    do_xfer(1'b1, 12'h004, 3'd2, 4'b0001, 32'h12345678, 0, 1'b0, 1'b0);
    chk_eq("mem_after_write", mem[1], 32'h12345678);
    idle(1);
    mem[1] = 32'hCAFEF00D;
    do_xfer(1'b0, 12'h004, 3'd2, 4'b0001, 32'h0, 0, 1'b0, 1'b0);
    idle(1);
    do_xfer(1'b1, 12'h003, 3'd0, 4'b0001, 32'hAB000000, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 12'h002, 3'd1, 4'b0011, 32'h5A5A0000, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 12'h000, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 12'h008, 3'd2, 4'b0010, 32'h0, 3, 1'b0, 1'b0);
    idle(2);
    do_xfer(1'b1, 12'h010, 3'd2, 4'b0000, 32'hDEADBEEF, 1, 1'b1, 1'b0);
    do_xfer(1'b0, 12'h014, 3'd2, 4'b0000, 32'h0, 0, 1'b1, 1'b0);
    idle(1);
    do_xfer(1'b1, 12'h020, 3'd2, 4'b0000, 32'h11111111, 5, 1'b0, 1'b1);
    idle(2);

    for (int t = 0; t < 150; t++) begin
      pdiv = $urandom_range(1, 3);
      sz   = 3'($urandom_range(0, 2));
      a    = AW'({$urandom_range(0, 15), 2'b00}) | AW'($urandom_range(0, 3));
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      do_xfer(1'($urandom), a, sz, 4'($urandom), $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
